// File: rtl/sort_result_serializer.sv
// Serializer behind the bitonic sorter: captures one sorted vector and
// streams it out one word per cycle, ascending or reversed, over valid/ready.
module sort_result_serializer #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vec_valid,
   input  logic [0:WIDTH-1] vec_in [0:DEPTH-1],
   input  logic             rev,
   output logic             vec_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:WIDTH-1] out_data,
   output logic [IDXW-1:0]  out_index,
   output logic             out_last,
   output logic [15:0]      vec_count
);

   localparam logic [IDXW-1:0] LAST_PTR = IDXW'(DEPTH - 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t state, state_next;

   logic [0:WIDTH-1] buffer [0:DEPTH-1];
   logic             rev_q;
   logic [IDXW-1:0]  ptr;
   logic [IDXW-1:0]  sel;
   logic             alive;
   logic             capture;
   logic             advance;
   logic             finish;

   // State register; reset discards any vector in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Keeps vec_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alive <= 1'b0;
      end else begin
         alive <= 1'b1;
      end
   end

   // Next-state and handshake decode; a new vector is only taken at a
   // full-vector boundary, so out_ready feeds vec_ready combinationally.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      vec_ready  = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      case (state)
         IDLE: begin
            vec_ready = alive;
            if (vec_valid && alive) begin
               capture    = 1'b1;
               state_next = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            out_last  = (ptr == LAST_PTR);
            if (out_ready) begin
               if (ptr == LAST_PTR) begin
                  finish    = 1'b1;
                  vec_ready = 1'b1;
                  if (vec_valid) begin
                     capture = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Vector buffer, latched direction and emit pointer; all hold during a stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            buffer[i] <= '0;
         end
         rev_q <= 1'b0;
         ptr   <= '0;
      end else if (capture) begin
         buffer <= vec_in;
         rev_q  <= rev;
         ptr    <= '0;
      end else if (advance) begin
         ptr <= ptr + 1'b1;
      end else if (finish) begin
         ptr <= '0;
      end
   end

   // Completed-vector counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vec_count <= '0;
      end else if (finish) begin
         vec_count <= vec_count + 16'd1;
      end
   end

   // Output word is selected purely from registered buffer, direction and pointer.
   always_comb begin
      sel       = rev_q ? (LAST_PTR - ptr) : ptr;
      out_data  = buffer[sel];
      out_index = ptr;
   end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Randomized self-checking bench with a word-queue reference model.
module tb_sort_result_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // DEPTH=8, WIDTH=32 instance
   logic        v_valid8;
   logic [0:31] v_in8 [0:7];
   logic        rev8;
   logic        vec_ready8;
   logic        o_valid8;
   logic        o_ready8;
   logic [0:31] o_data8;
   logic [2:0]  o_idx8;
   logic        o_last8;
   logic [15:0] cnt8;

   // DEPTH=1, WIDTH=8 instance
   logic        v_valid1;
   logic [0:7]  v_in1 [0:0];
   logic        rev1;
   logic        vec_ready1;
   logic        o_valid1;
   logic        o_ready1;
   logic [0:7]  o_data1;
   logic [0:0]  o_idx1;
   logic        o_last1;
   logic [15:0] cnt1;

   sort_result_serializer #(.DEPTH(8), .WIDTH(32)) dut8 (
      .clk(clk), .rst(rst), .vec_valid(v_valid8), .vec_in(v_in8), .rev(rev8),
      .vec_ready(vec_ready8), .out_valid(o_valid8), .out_ready(o_ready8),
      .out_data(o_data8), .out_index(o_idx8), .out_last(o_last8), .vec_count(cnt8)
   );

   sort_result_serializer #(.DEPTH(1), .WIDTH(8)) dut1 (
      .clk(clk), .rst(rst), .vec_valid(v_valid1), .vec_in(v_in1), .rev(rev1),
      .vec_ready(vec_ready1), .out_valid(o_valid1), .out_ready(o_ready1),
      .out_data(o_data1), .out_index(o_idx1), .out_last(o_last1), .vec_count(cnt1)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  idx;
      logic        last;
   } exp_t;

   typedef struct packed {
      logic [7:0][31:0] w;
      logic             rev;
   } pend_t;

   int checks = 0;
   int errors = 0;

   exp_t        q8[$];
   pend_t       pend[$];
   logic [15:0] model_cnt8 = '0;
   bit          presenting = 0;
   bit          gaps = 0;
   bit          rand_ready = 0;
   bit          stall_armed = 0;
   int          stall_left = 0;
   int          run_len = 0;
   int          max_run = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic pushSeq(input int base, input int step, input bit r);
      pend_t p;
      for (int i = 0; i < 8; i++) p.w[i] = 32'(base + step * i);
      p.rev = r;
      pend.push_back(p);
   endtask

   // Drive upstream vector and downstream ready for the coming cycle.
   task automatic applyStimulus();
      if (!presenting && pend.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) presenting = 1;
      if (presenting) begin
         v_valid8 = 1'b1;
         for (int i = 0; i < 8; i++) v_in8[i] = pend[0].w[i];
         rev8 = pend[0].rev;
      end else begin
         v_valid8 = 1'b0;
         for (int i = 0; i < 8; i++) v_in8[i] = $urandom;
         rev8 = 1'($urandom_range(0, 1));
      end
      if (stall_left > 0) begin
         o_ready8 = 1'b0;
         stall_left--;
      end else if (stall_armed && q8.size() > 0 && q8[0].idx == 3'd4) begin
         stall_armed = 0;
         o_ready8 = 1'b0;
         stall_left = 2;
      end else if (rand_ready) begin
         o_ready8 = ($urandom_range(0, 3) != 0);
      end else begin
         o_ready8 = 1'b1;
      end
   endtask

   // One cycle: check outputs against the model, advance the model, drive next inputs.
   task automatic runCycle();
      exp_t  w;
      pend_t p;
      logic  exp_ready;
      logic  xfer;
      @(negedge clk);
      if (o_valid8) run_len++; else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      exp_ready = (q8.size() == 0) || (q8[0].last && o_ready8);
      checkOutput("out_valid", 64'(o_valid8), 64'(q8.size() > 0));
      checkOutput("vec_ready", 64'(vec_ready8), 64'(exp_ready));
      checkOutput("vec_count", 64'(cnt8), 64'(model_cnt8));
      if (q8.size() > 0) begin
         checkOutput("out_data", 64'(o_data8), 64'(q8[0].data));
         checkOutput("out_index", 64'(o_idx8), 64'(q8[0].idx));
         checkOutput("out_last", 64'(o_last8), 64'(q8[0].last));
      end
      xfer = (q8.size() > 0) && o_ready8;
      if (xfer) begin
         w = q8.pop_front();
         if (w.last) model_cnt8 = model_cnt8 + 16'd1;
      end
      if (exp_ready && v_valid8 && pend.size() > 0) begin
         p = pend.pop_front();
         presenting = 0;
         for (int i = 0; i < 8; i++) begin
            w.data = p.rev ? p.w[7 - i] : p.w[i];
            w.idx  = 3'(i);
            w.last = (i == 7);
            q8.push_back(w);
         end
      end
      @(posedge clk);
      #1;
      applyStimulus();
   endtask

   task automatic runUntilIdle(input int limit);
      int n = 0;
      while ((pend.size() > 0 || q8.size() > 0) && n < limit) begin
         runCycle();
         n++;
      end
      if (n >= limit) checkOutput("idle_timeout", 64'(n), 64'(0));
      runCycle();
   endtask

   initial begin
      pend_t       p;
      logic [7:0]  q1[$];
      logic [15:0] mcnt1;
      int          sent1;
      int          done1;
      int          n;

      rst = 1'b0;
      v_valid8 = 1'b0; rev8 = 1'b0; o_ready8 = 1'b1;
      for (int i = 0; i < 8; i++) v_in8[i] = '0;
      v_valid1 = 1'b0; rev1 = 1'b0; o_ready1 = 1'b1; v_in1[0] = '0;
      #1;
      checkOutput("reset_out_valid", 64'(o_valid8), 64'(0));
      checkOutput("reset_vec_ready", 64'(vec_ready8), 64'(0));
      checkOutput("reset_vec_count", 64'(cnt8), 64'(0));
      checkOutput("reset_out_data", 64'(o_data8), 64'(0));
      checkOutput("reset_out_index", 64'(o_idx8), 64'(0));
      checkOutput("reset_out_last", 64'(o_last8), 64'(0));
      #20;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus();

      $display("[TB] ascending vector");
      pushSeq(1, 1, 0);
      runUntilIdle(100);
      checkOutput("asc_count", 64'(cnt8), 64'(1));

      $display("[TB] reversed vector");
      pushSeq(1, 1, 1);
      runUntilIdle(100);
      checkOutput("rev_count", 64'(cnt8), 64'(2));

      $display("[TB] back-to-back vectors");
      max_run = 0; run_len = 0;
      pushSeq(0, 1, 0);
      pushSeq(10, 1, 0);
      runUntilIdle(100);
      checkOutput("b2b_run", 64'(max_run), 64'(16));
      checkOutput("b2b_count", 64'(cnt8), 64'(4));

      $display("[TB] backpressure on word 4");
      stall_armed = 1;
      pushSeq(1, 1, 0);
      runUntilIdle(100);
      checkOutput("stall_count", 64'(cnt8), 64'(5));

      $display("[TB] randomized traffic");
      gaps = 1; rand_ready = 1;
      for (int k = 0; k < 80; k++) begin
         for (int i = 0; i < 8; i++) p.w[i] = $urandom;
         p.rev = 1'($urandom_range(0, 1));
         pend.push_back(p);
      end
      runUntilIdle(4000);
      gaps = 0; rand_ready = 0;

      $display("[TB] reset mid-stream");
      pushSeq(1, 1, 0);
      n = 0;
      while (!(q8.size() > 0 && q8[0].idx == 3'd3) && n < 50) begin
         runCycle();
         n++;
      end
      if (n >= 50) checkOutput("reach_idx3_timeout", 64'(n), 64'(0));
      rst = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 64'(o_valid8), 64'(0));
      checkOutput("midrst_vec_count", 64'(cnt8), 64'(0));
      checkOutput("midrst_vec_ready", 64'(vec_ready8), 64'(0));
      q8.delete(); pend.delete(); presenting = 0; model_cnt8 = '0;
      v_valid8 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus();
      pushSeq(9, 0, 0);
      runUntilIdle(100);
      checkOutput("post_rst_count", 64'(cnt8), 64'(1));

      $display("[TB] DEPTH=1 streaming and counter wrap");
      mcnt1 = '0; sent1 = 0; done1 = 0; n = 0;
      v_valid1 = 1'b1; v_in1[0] = 8'h11; sent1 = 0;
      while ((done1 < 65536 || q1.size() > 0) && n < 70000) begin
         @(negedge clk);
         checkOutput("d1_out_valid", 64'(o_valid1), 64'(q1.size() > 0));
         checkOutput("d1_vec_ready", 64'(vec_ready1), 64'(1));
         checkOutput("d1_vec_count", 64'(cnt1), 64'(mcnt1));
         if (q1.size() > 0) begin
            checkOutput("d1_out_data", 64'(o_data1), 64'(q1[0]));
            checkOutput("d1_out_last", 64'(o_last1), 64'(1));
            checkOutput("d1_out_index", 64'(o_idx1), 64'(0));
            void'(q1.pop_front());
            done1++;
            mcnt1 = mcnt1 + 16'd1;
         end
         if (v_valid1) begin
            q1.push_back(v_in1[0]);
            sent1++;
         end
         @(posedge clk);
         #1;
         if (sent1 < 65536) begin
            v_valid1 = 1'b1;
            case (sent1)
               1: v_in1[0] = 8'h22;
               2: v_in1[0] = 8'h33;
               default: v_in1[0] = 8'($urandom);
            endcase
            rev1 = 1'($urandom_range(0, 1));
         end else begin
            v_valid1 = 1'b0;
         end
         n++;
      end
      if (n >= 70000) checkOutput("d1_timeout", 64'(n), 64'(0));
      @(negedge clk);
      checkOutput("d1_wrap_count", 64'(cnt1), 64'(0));
      checkOutput("d1_idle_valid", 64'(o_valid1), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
